// File: rtl/bus_pkg.sv
// Shared definitions for both ends of the serial master/slave bus:
// frame state encoding, read/write bit values and default frame geometry.
package bus_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_TIMEOUT    = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WRITE,
    ST_RREQ,
    ST_RWAIT,
    ST_RDATA,
    ST_DONE
  } slave_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first serial shift register with parallel load. Shifting moves bit n+1
// into bit n and inserts sin at the MSB; nxt is the value after this edge.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (shift) begin
      q_d = {sin, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign nxt = q_d;

endmodule

// File: rtl/serial_bus_slave_port.sv
// Slave end of the serial bus: deserialises a read/write frame, performs one
// access on the local synchronous memory and serialises read data back.
module serial_bus_slave_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic                  s_rw,
  input  logic                  s_din,
  output logic                  s_ready,
  output logic                  s_dout,
  output logic                  s_dout_valid,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(max_u(ADDR_WIDTH, DATA_WIDTH) + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  slave_state_e          state_q, state_d;
  logic                  rw_q, rw_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic                  done_q, done_d;
  logic                  s_dout_q, s_dout_d;
  logic                  s_dout_valid_q, s_dout_valid_d;

  logic                  addr_shift, wdata_shift, rd_load, rd_shift;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt, rd_nxt;
  logic                  unused_rd_hi;

  serial_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk(clk), .rst_n(reset), .load(1'b0), .shift(addr_shift),
    .sin(s_din), .d('0), .nxt(addr_nxt)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_wdata_sr (
    .clk(clk), .rst_n(reset), .load(1'b0), .shift(wdata_shift),
    .sin(s_din), .d('0), .nxt(wdata_nxt)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_rdata_sr (
    .clk(clk), .rst_n(reset), .load(rd_load), .shift(rd_shift),
    .sin(1'b0), .d(mem_rdata), .nxt(rd_nxt)
  );

  // Only bit 0 of the read shifter leaves the block.
  assign unused_rd_hi = ^rd_nxt[DATA_WIDTH-1:1];

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    addr_shift  = 1'b0;
    wdata_shift = 1'b0;
    rd_load     = 1'b0;
    rd_shift    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          rw_d    = s_rw ? RW_READ : RW_WRITE;
          cnt_d   = '0;
          to_d    = '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (s_valid) begin
          to_d       = '0;
          addr_shift = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d      = '0;
            mem_addr_d = addr_nxt;
            state_d    = (rw_q == RW_WRITE) ? ST_WDATA : ST_RREQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (to_q == TO_LAST) begin
          to_d    = '0;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_WDATA: begin
        if (s_valid) begin
          to_d        = '0;
          wdata_shift = 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_d       = '0;
            mem_wdata_d = wdata_nxt;
            state_d     = ST_WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (to_q == TO_LAST) begin
          to_d    = '0;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_RREQ:  state_d = ST_RWAIT;
      ST_RWAIT: begin
        rd_load = 1'b1;
        cnt_d   = '0;
        state_d = ST_RDATA;
      end
      ST_RDATA: begin
        rd_shift = 1'b1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Strobes are registered off the next state so they line up with it.
    mem_we_d       = (state_d == ST_WRITE);
    mem_re_d       = (state_d == ST_RREQ);
    done_d         = (state_d == ST_DONE);
    s_dout_valid_d = (state_d == ST_RDATA);
    s_dout_d       = (state_d == ST_RDATA) ? rd_nxt[0] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      rw_q           <= RW_WRITE;
      cnt_q          <= '0;
      to_q           <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_we_q       <= 1'b0;
      mem_re_q       <= 1'b0;
      done_q         <= 1'b0;
      s_dout_q       <= 1'b0;
      s_dout_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rw_q           <= rw_d;
      cnt_q          <= cnt_d;
      to_q           <= to_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_we_q       <= mem_we_d;
      mem_re_q       <= mem_re_d;
      done_q         <= done_d;
      s_dout_q       <= s_dout_d;
      s_dout_valid_q <= s_dout_valid_d;
    end
  end

  assign s_ready      = (state_q == ST_IDLE);
  assign s_dout       = s_dout_q;
  assign s_dout_valid = s_dout_valid_q;
  assign done         = done_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign mem_re       = mem_re_q;

endmodule

// File: tb/tb_serial_bus_slave_port.sv
// Scoreboard bench for serial_bus_slave_port: the driver predicts each frame's
// memory strobes, serial read bits and done pulse with their cycle numbers.
module tb_serial_bus_slave_port;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;
  localparam int EV_WE = 0, EV_RE = 1, EV_BIT = 2, EV_DONE = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [19:0] val;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_rw = 1'b0;
  logic          s_din = 1'b0;
  logic          s_ready, s_dout, s_dout_valid, done, mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  int  stall_plan[20];
  bit  hold_valid = 1'b0;
  ev_t exp_q[$];

  logic [DW-1:0] env_mem [4096];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  serial_bus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_rw(s_rw), .s_din(s_din),
    .s_ready(s_ready), .s_dout(s_dout), .s_dout_valid(s_dout_valid), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'((int'(a) * 151 + 7) & 255);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Local synchronous memory the slave talks to.
  initial for (int i = 0; i < 4096; i++) env_mem[i] = init_val(AW'(i));
  always @(posedge clk) begin
    if (mem_we) env_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= env_mem[mem_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic push_ev(input int kind, input int c, input logic [19:0] val);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind, input logic [19:0] val);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_output kind %0d val %0h at cycle %0d, nothing expected", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.cyc == cyc && e.val === val) n_pass++;
      else $display("FAIL scoreboard: got kind %0d cycle %0d val %0h, expected kind %0d cycle %0d val %0h",
                    kind, cyc, val, e.kind, e.cyc, e.val);
    end
  endtask

  // Monitor: every output event is matched against the next expected one.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_we)       check_event(EV_WE, {mem_addr, mem_wdata});
      if (mem_re)       check_event(EV_RE, {mem_addr, 8'h00});
      if (s_dout_valid) check_event(EV_BIT, 20'(s_dout));
      if (done)         check_event(EV_DONE, 20'h0);
    end
  end

  task automatic clear_plan();
    for (int i = 0; i < 20; i++) stall_plan[i] = 0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) next_cycle();
  endtask

  // Drives one frame from an idle slave; returns on the cycle s_ready should be back.
  task automatic run_frame(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int nbits, tl, tend;
    logic [DW-1:0] rd;
    chk("ready_before_start", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_rw = rw; s_din = 1'($urandom);
    next_cycle();
    nbits = rw ? int'(AW) : int'(AW + DW);
    for (int i = 0; i < nbits; i++) begin
      for (int s = 0; s < stall_plan[i]; s++) begin
        s_valid = 1'b0; s_rw = 1'($urandom); s_din = 1'($urandom);
        next_cycle();
      end
      s_valid = 1'b1; s_rw = 1'($urandom);
      s_din = (i < int'(AW)) ? addr[i] : data[i - int'(AW)];
      next_cycle();
    end
    tl = cyc - 1;
    if (!rw) begin
      push_ev(EV_WE, tl + 1, {addr, data});
      push_ev(EV_DONE, tl + 2, 20'h0);
      ref_mem[addr] = data;
      tend = tl + 3;
    end else begin
      rd = ref_rd(addr);
      push_ev(EV_RE, tl + 1, {addr, 8'h00});
      for (int k = 0; k < int'(DW); k++) push_ev(EV_BIT, tl + 3 + k, 20'(rd[k]));
      push_ev(EV_DONE, tl + 3 + int'(DW), 20'h0);
      tend = tl + 4 + int'(DW);
    end
    while (cyc < tend) begin
      s_valid = hold_valid ? 1'b1 : 1'($urandom);
      s_rw = 1'($urandom); s_din = 1'($urandom);
      if (cyc == tend - 1) chk("busy_during_done", 32'(s_ready), 32'd0);
      next_cycle();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_plan();
    reset = 1'b0;
    repeat (3) next_cycle();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_s_dout", 32'(s_dout), 32'd0);
    chk("rst_s_dout_valid", 32'(s_dout_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b1;
    next_cycle();

    // Directed write/read of 12'h3E9 <- 8'h65, then a stalled write.
    run_frame(1'b0, 12'h3E9, 8'h65);
    idle(2);
    run_frame(1'b1, 12'h3E9, 8'h00);
    idle(2);
    stall_plan[6] = 3; stall_plan[15] = 2;
    run_frame(1'b0, 12'h123, 8'hA7);
    idle(1);
    // One short of the timeout in both address and data must not abort.
    clear_plan();
    stall_plan[3] = int'(TO) - 1; stall_plan[14] = int'(TO) - 1;
    run_frame(1'b0, 12'h0FF, 8'h5A);
    clear_plan();
    run_frame(1'b1, 12'h0FF, 8'h00);
    idle(2);

    // Timeout after 5 address bits.
    s_valid = 1'b1; s_rw = 1'b0; s_din = 1'b1;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      s_din = 1'($urandom);
      next_cycle();
    end
    s_valid = 1'b0;
    repeat (TO - 1) next_cycle();
    chk("timeout_minus1_busy", 32'(s_ready), 32'd0);
    next_cycle();
    chk("timeout_idle", 32'(s_ready), 32'd1);
    chk("timeout_no_done", 32'(done), 32'd0);
    idle(3);

    // Reset at T17 of a write frame.
    s_valid = 1'b1; s_rw = 1'b0; s_din = 1'b0;
    next_cycle();
    for (int i = 1; i <= 16; i++) begin
      s_din = 1'($urandom);
      next_cycle();
    end
    reset = 1'b0;
    next_cycle();
    reset = 1'b1; s_valid = 1'b0;
    chk("reset_mid_idle", 32'(s_ready), 32'd1);
    chk("reset_mid_addr", 32'(mem_addr), 32'd0);
    chk("reset_mid_wdata", 32'(mem_wdata), 32'd0);
    chk("reset_mid_no_we", 32'(mem_we), 32'd0);
    idle(2);
    run_frame(1'b0, 12'hC31, 8'h9E);
    idle(1);

    // Back-to-back with s_valid held high through WRITE/DONE.
    hold_valid = 1'b1;
    run_frame(1'b0, 12'h777, 8'h3C);
    run_frame(1'b1, 12'h777, 8'h00);
    run_frame(1'b1, 12'hC31, 8'h00);
    hold_valid = 1'b0;
    idle(2);

    // Randomised frames over a small address pool so reads hit earlier writes.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 20; i++)
        stall_plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      hold_valid = 1'($urandom);
      run_frame(1'($urandom), AW'($urandom_range(0, 15) * 257), DW'($urandom));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    hold_valid = 1'b0;
    idle(6);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
